// File: rtl/dmem_responder_if.sv
// Memory-stage dmem bus: request fields driven by the pipeline, and load data,
// stall and fault returned by the responder.
interface dmem_responder_if;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_in;
  logic        dmem_write;
  logic        dmem_read;
  logic [2:0]  dmem_mode;
  logic [31:0] dmem_out;
  logic        dmem_stall;
  logic        dmem_fault;

  modport master (
    output dmem_addr, dmem_in, dmem_write, dmem_read, dmem_mode,
    input  dmem_out, dmem_stall, dmem_fault
  );

  modport slave (
    input  dmem_addr, dmem_in, dmem_write, dmem_read, dmem_mode,
    output dmem_out, dmem_stall, dmem_fault
  );
endinterface

// File: rtl/dmem_responder.sv
// Multi-cycle data SRAM responder: stalls the pipeline for LATENCY+1 cycles,
// performs byte-lane merged stores and returns sign/zero-extended loads.
module dmem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  dmem_responder_if.slave bus
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int CW = $clog2(LATENCY + 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   out_q, out_d;
  logic          fault_q, fault_d;
  logic          stall;

  logic          req;
  logic [AW-1:0] word_idx;
  logic [1:0]    lane;
  logic          is_byte, is_half, is_word, is_unsigned;
  logic          misaligned;
  logic          last_cycle;
  logic          commit;
  logic [31:0]   rdata;
  logic [7:0]    byte_v;
  logic [15:0]   half_v;
  logic [31:0]   load_v;
  logic          unused_addr_bits;

  assign req         = bus.dmem_read | bus.dmem_write;
  assign word_idx    = bus.dmem_addr[AW+1:2];
  assign lane        = bus.dmem_addr[1:0];
  assign is_byte     = (bus.dmem_mode[1:0] == 2'b00);
  assign is_half     = (bus.dmem_mode[1:0] == 2'b01);
  assign is_word     = ~is_byte & ~is_half;
  assign is_unsigned = bus.dmem_mode[2];
  assign misaligned  = (is_half & lane[0]) | (is_word & (lane != 2'b00));
  assign last_cycle  = (state_q == BUSY) && (cnt_q == '0);
  assign commit      = last_cycle & bus.dmem_write & ~misaligned;
  assign unused_addr_bits = ^bus.dmem_addr[31:AW+2];

  // One RAM per byte lane so a sub-word store is a plain lane write-enable.
  // The read port is registered every cycle; the address has been stable since
  // the request was first seen, so rd_q is current by the completing edge.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      localparam logic [1:0] LANE = 2'(gi);
      logic [7:0] mem [DEPTH_WORDS];
      logic [7:0] rd_q;
      logic       we;
      logic [7:0] wdata;

      assign we    = commit & (is_word
                               | (is_half & (lane[1] == LANE[1]))
                               | (is_byte & (lane == LANE)));
      assign wdata = is_word ? bus.dmem_in[8*gi +: 8]
                   : is_half ? bus.dmem_in[8*(gi%2) +: 8]
                   : bus.dmem_in[7:0];

      always_ff @(posedge clk) begin
        if (we) begin
          mem[word_idx] <= wdata;
        end
        rd_q <= mem[word_idx];
      end

      assign rdata[8*gi +: 8] = rd_q;
    end
  endgenerate

  always_comb begin
    byte_v = rdata[{lane, 3'b000} +: 8];
    half_v = lane[1] ? rdata[31:16] : rdata[15:0];
    if (is_byte) begin
      load_v = {{24{~is_unsigned & byte_v[7]}}, byte_v};
    end else if (is_half) begin
      load_v = {{16{~is_unsigned & half_v[15]}}, half_v};
    end else begin
      load_v = rdata;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
    fault_d = 1'b0;
    stall   = 1'b0;
    case (state_q)
      IDLE: begin
        if (req) begin
          stall   = 1'b1;
          cnt_d   = CW'(LATENCY - 1);
          state_d = BUSY;
        end
      end
      BUSY: begin
        stall = 1'b1;
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          state_d = DONE;
          fault_d = misaligned;
          // A store leaves the last load value in place unless it faults or
          // arrived together with a read.
          if (misaligned || bus.dmem_write) begin
            if (misaligned || bus.dmem_read) begin
              out_d = '0;
            end
          end else begin
            out_d = load_v;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      out_q   <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      fault_q <= fault_d;
    end
  end

  // Stall is combinational from req in IDLE, so gate it while reset is held.
  assign bus.dmem_stall = stall & rst_n;
  assign bus.dmem_out   = out_q;
  assign bus.dmem_fault = fault_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Randomised bench for dmem_responder: every access is checked against a
// word-array reference model for latency, load data and fault flag.
module tb_dmem_responder;
  localparam int DEPTH = 1024;
  localparam int LAT   = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dmem_responder_if bus();

  dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [31:0] mem_m [DEPTH];
  logic [31:0] out_m = '0;
  int          n_vec = 0;
  int          n_err = 0;
  time         done_t = 0;
  time         prev_done = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] fmt(input logic [2:0] m, input logic [31:0] w, input logic [1:0] a);
    logic [7:0]         b;
    logic [15:0]        h;
    logic signed [31:0] sb, sh;
    b  = 8'(w >> (8 * a));
    h  = a[1] ? w[31:16] : w[15:0];
    sb = $signed(b);
    sh = $signed(h);
    case (m)
      3'b000:  return sb;
      3'b001:  return sh;
      3'b100:  return {24'h0, b};
      3'b101:  return {16'h0, h};
      default: return w;
    endcase
  endfunction

  // Leaves the request applied when it returns at the DONE cycle, so a
  // following call is back-to-back exactly as a pipeline would issue it.
  task automatic xact(input logic rd, input logic wr, input logic [2:0] m,
                      input logic [31:0] a, input logic [31:0] d);
    logic [31:0] exp_out, w;
    logic        exp_f, half, byt;
    int          idx, cyc;
    idx   = int'((a >> 2) % DEPTH);
    half  = (m == 3'b001) || (m == 3'b101);
    byt   = (m == 3'b000) || (m == 3'b100);
    exp_f = (half && a[0]) || (!half && !byt && (a[1:0] != 2'b00));
    if (exp_f) begin
      exp_out = '0;
    end else if (wr) begin
      w = mem_m[idx];
      if (byt)       w[8*a[1:0] +: 8] = d[7:0];
      else if (half) w[16*a[1] +: 16] = d[15:0];
      else           w = d;
      mem_m[idx] = w;
      exp_out = rd ? 32'h0 : out_m;
    end else begin
      exp_out = fmt(m, mem_m[idx], a[1:0]);
    end
    out_m = exp_out;

    @(posedge clk); #1;
    bus.dmem_read  = rd;
    bus.dmem_write = wr;
    bus.dmem_mode  = m;
    bus.dmem_addr  = a;
    bus.dmem_in    = d;
    @(negedge clk);
    chk("fault_before_done", {31'h0, bus.dmem_fault}, 32'h0);
    cyc = 0;
    while (bus.dmem_stall === 1'b1 && cyc < 20) begin
      cyc++;
      @(negedge clk);
    end
    chk("stall_cycles", cyc, LAT + 1);
    chk("done_out", bus.dmem_out, exp_out);
    chk("done_fault", {31'h0, bus.dmem_fault}, {31'h0, exp_f});
    prev_done = done_t;
    done_t    = $time;
    $display("xact rd=%0b wr=%0b mode=%03b addr=%08h din=%08h -> out=%08h fault=%0b",
             rd, wr, m, a, d, bus.dmem_out, bus.dmem_fault);
  endtask

  task automatic idle();
    @(posedge clk); #1;
    bus.dmem_read  = 1'b0;
    bus.dmem_write = 1'b0;
    @(negedge clk);
    chk("idle_stall", {31'h0, bus.dmem_stall}, 32'h0);
    chk("idle_fault", {31'h0, bus.dmem_fault}, 32'h0);
    chk("idle_hold", bus.dmem_out, out_m);
  endtask

  initial begin
    logic [1:0] op;
    bus.dmem_read  = 1'b0;
    bus.dmem_write = 1'b0;
    bus.dmem_mode  = 3'b010;
    bus.dmem_addr  = '0;
    bus.dmem_in    = '0;
    repeat (2) @(negedge clk);
    chk("rst_out", bus.dmem_out, 32'h0);
    chk("rst_stall", {31'h0, bus.dmem_stall}, 32'h0);
    chk("rst_fault", {31'h0, bus.dmem_fault}, 32'h0);
    rst_n = 1'b1;

    // Word store/load
    xact(0, 1, 3'b010, 32'h100, 32'hDEADBEEF); idle();
    xact(1, 0, 3'b010, 32'h100, 32'h0);
    chk("plan_lw", bus.dmem_out, 32'hDEADBEEF); idle();

    // Sign handling
    xact(0, 1, 3'b010, 32'h200, 32'h80FF7F01); idle();
    xact(1, 0, 3'b000, 32'h202, 32'h0); chk("plan_lb", bus.dmem_out, 32'hFFFFFFFF); idle();
    xact(1, 0, 3'b100, 32'h202, 32'h0); chk("plan_lbu", bus.dmem_out, 32'h000000FF); idle();
    xact(1, 0, 3'b001, 32'h202, 32'h0); chk("plan_lh", bus.dmem_out, 32'hFFFF80FF); idle();
    xact(1, 0, 3'b101, 32'h200, 32'h0); chk("plan_lhu", bus.dmem_out, 32'h00007F01); idle();
    xact(1, 0, 3'b000, 32'h200, 32'h0); chk("plan_lb0", bus.dmem_out, 32'h00000001); idle();

    // Lane merge
    xact(0, 1, 3'b010, 32'h300, 32'h11223344); idle();
    xact(0, 1, 3'b000, 32'h301, 32'h777777AA); idle();
    xact(1, 0, 3'b010, 32'h300, 32'h0); chk("plan_sb", bus.dmem_out, 32'h1122AA44); idle();
    xact(0, 1, 3'b001, 32'h302, 32'h9999BBCC); idle();
    xact(1, 0, 3'b010, 32'h300, 32'h0); chk("plan_sh", bus.dmem_out, 32'hBBCCAA44); idle();

    // Misalignment
    xact(0, 1, 3'b010, 32'h304, 32'h0BADCAFE); idle();
    xact(0, 1, 3'b010, 32'h305, 32'h12345678); chk("plan_mis_out", bus.dmem_out, 32'h0); idle();
    xact(1, 0, 3'b010, 32'h304, 32'h0); chk("plan_mis_keep", bus.dmem_out, 32'h0BADCAFE); idle();
    xact(1, 0, 3'b001, 32'h301, 32'h0); chk("plan_mis_lh", {31'h0, bus.dmem_fault}, 32'h1); idle();

    // Reset during the first BUSY cycle abandons the store
    xact(0, 1, 3'b010, 32'h400, 32'h0); idle();
    xact(1, 0, 3'b010, 32'h100, 32'h0); idle();
    @(posedge clk); #1;
    bus.dmem_write = 1'b1;
    bus.dmem_mode  = 3'b010;
    bus.dmem_addr  = 32'h400;
    bus.dmem_in    = 32'hCAFEF00D;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_stall", {31'h0, bus.dmem_stall}, 32'h0);
    chk("midrst_out", bus.dmem_out, 32'h0);
    chk("midrst_fault", {31'h0, bus.dmem_fault}, 32'h0);
    bus.dmem_write = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    out_m = '0;
    idle();
    xact(1, 0, 3'b010, 32'h400, 32'h0); chk("plan_rst_mem", bus.dmem_out, 32'h0); idle();

    // Wrap
    xact(0, 1, 3'b010, 32'h1000, 32'h55AA55AA); idle();
    xact(1, 0, 3'b010, 32'h0000, 32'h0); chk("plan_wrap", bus.dmem_out, 32'h55AA55AA);

    // Back-to-back fill of the random test region
    for (int i = 0; i < 64; i++) begin
      xact(0, 1, 3'b010, 32'(i * 4), $urandom);
      chk("b2b_spacing", 32'(done_t - prev_done), 32'((LAT + 2) * 10));
    end
    idle();

    for (int i = 0; i < 200; i++) begin
      op = 2'($urandom_range(0, 3));
      xact(op == 2'd0 || op == 2'd2 || op == 2'd3, op == 2'd1 || op == 2'd2,
           3'($urandom_range(0, 7)), $urandom & 32'hFFFF_F0FF, $urandom);
      if ($urandom_range(0, 1) == 0) idle();
    end
    idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
